// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;
  localparam int COUNT_W        = 16;

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - packs little-endian stream bytes into 32-bit words
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_cnt;
  logic [23:0] low_q;

  // The final byte is not stored: the word is presented combinationally on its accept
  assign word       = {byte_in, low_q};
  assign word_valid = byte_valid && (byte_cnt == 2'(BYTES_PER_WORD - 1));

  // Byte position counter and storage of the three low bytes of the word in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 2'd0;
      low_q    <= 24'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      low_q    <= 24'd0;
    end else if (byte_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    low_q[7:0]   <= byte_in;
        2'd1:    low_q[15:8]  <= byte_in;
        2'd2:    low_q[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time loader writing a checksummed byte stream into instruction memory
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_byte,
  output logic          rx_ready,
  output logic          imem_write,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_data,
  output logic          cpu_hold,
  output logic          done,
  output logic          error,
  output logic [15:0]   words_loaded
);

  state_t               state;
  logic [7:0]           csum_acc;
  logic [7:0]           len_lo;
  logic [COUNT_W-1:0]   count;

  logic                 accept;
  logic                 restart;
  logic [7:0]           csum_next;
  logic [COUNT_W-1:0]   hdr_count;
  logic [31:0]          word;
  logic                 word_valid;

  assign accept    = rx_valid && rx_ready;
  assign restart   = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign csum_next = csum_acc ^ rx_byte;
  assign hdr_count = {rx_byte, len_lo};

  imem_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (restart),
    .byte_valid (accept && (state == DATA)),
    .byte_in    (rx_byte),
    .word       (word),
    .word_valid (word_valid)
  );

  // Load sequencer: header, word writes, checksum verdict; all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rx_ready     <= 1'b0;
      imem_write   <= 1'b0;
      imem_addr    <= '0;
      imem_data    <= 32'd0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 16'd0;
      csum_acc     <= 8'd0;
      len_lo       <= 8'd0;
      count        <= '0;
    end else begin
      imem_write <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= LEN0;
            csum_acc     <= 8'd0;
            words_loaded <= 16'd0;
            imem_addr    <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_hold     <= 1'b1;
            rx_ready     <= 1'b1;
          end
        end
        LEN0: begin
          if (accept) begin
            len_lo   <= rx_byte;
            csum_acc <= csum_next;
            state    <= LEN1;
          end
        end
        LEN1: begin
          if (accept) begin
            csum_acc <= csum_next;
            count    <= hdr_count;
            if (hdr_count > COUNT_W'(DEPTH)) begin
              state    <= ERR;
              error    <= 1'b1;
              rx_ready <= 1'b0;
            end else if (hdr_count == '0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (imem_write) begin
            // Write cycle just ended: advance the index and resume accepting bytes
            imem_addr    <= imem_addr + AW'(1);
            words_loaded <= words_loaded + 16'd1;
            rx_ready     <= 1'b1;
            if ((words_loaded + 16'd1) == count) state <= CSUM;
          end else if (accept) begin
            csum_acc <= csum_next;
            if (word_valid) begin
              imem_write <= 1'b1;
              imem_data  <= word;
              rx_ready   <= 1'b0;
            end
          end
        end
        CSUM: begin
          if (accept) begin
            csum_acc <= csum_next;
            rx_ready <= 1'b0;
            if (csum_next == 8'd0) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for the instruction memory loader
module tb_imem_loader;

  localparam int DEPTH = 32;
  localparam int AW    = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_byte;
  logic          rx_ready;
  logic          imem_write;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [15:0]   words_loaded;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stream [0:10];
  int         total = 0;
  int         bad   = 0;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .rx_ready     (rx_ready),
    .imem_write   (imem_write),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected write
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && imem_write) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_data);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", imem_addr, e.addr);
        check("write_data", imem_data, e.data);
        check("write_addr_range", 32'(imem_addr < DEPTH), 32'd1);
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n        = 0;
    rx_byte  = b;
    rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
      if (n > 50) begin
        total++;
        bad++;
        $display("FAIL rx_timeout: byte %h not accepted, expected acceptance within 50 cycles", b);
        rx_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1 rx_valid = 1'b0;
  endtask

  task automatic send_stream(input int n, input bit gaps, input bit mid_start);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
      end
      if (mid_start && (i == 4 || i == 6 || i == 8)) pulse_start();
      send_byte(stream[i]);
    end
  endtask

  task automatic set_nominal(input logic [7:0] last);
    stream = '{8'h02, 8'h00, 8'hb7, 8'h07, 8'h00, 8'h00, 8'h93, 8'h87, 8'h07, 8'h00, 8'ha1};
    stream[10] = last;
  endtask

  task automatic push_two_words();
    exp_q.push_back('{addr: 32'd0, data: 32'h000007b7});
    exp_q.push_back('{addr: 32'd1, data: 32'h00078793});
  endtask

  task automatic check_done_state(input string tag);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_cpu_hold"}, cpu_hold, 1'b0);
    check({tag, "_words"}, words_loaded, 16'd2);
    check({tag, "_rx_ready"}, rx_ready, 1'b0);
    check({tag, "_pending_writes"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;

    // 1: reset values, then idle with no start
    #12;
    check("rst_cpu_hold", cpu_hold, 1'b1);
    check("rst_imem_write", imem_write, 1'b0);
    check("rst_rx_ready", rx_ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_data", imem_data, 32'd0);
    check("rst_words", words_loaded, 16'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", {cpu_hold, rx_ready, imem_write, done, error}, 5'b10000);
    end

    // 2: nominal two-word load
    push_two_words();
    pulse_start();
    check("start_rx_ready", rx_ready, 1'b1);
    check("start_cpu_hold", cpu_hold, 1'b1);
    set_nominal(8'ha1);
    send_stream(11, 1'b0, 1'b0);
    check_done_state("nominal");

    // 3: bad checksum, restarted from DONE
    push_two_words();
    pulse_start();
    check("restart_done_cleared", done, 1'b0);
    check("restart_cpu_hold", cpu_hold, 1'b1);
    set_nominal(8'ha0);
    send_stream(11, 1'b0, 1'b0);
    check("badcsum_error", error, 1'b1);
    check("badcsum_done", done, 1'b0);
    check("badcsum_cpu_hold", cpu_hold, 1'b1);
    check("badcsum_words", words_loaded, 16'd2);
    check("badcsum_pending_writes", exp_q.size(), 32'd0);

    // 4: over-length header, restarted from ERR
    pulse_start();
    check("restart_error_cleared", error, 1'b0);
    stream[0] = 8'h21;
    stream[1] = 8'h00;
    send_stream(2, 1'b0, 1'b0);
    check("overlen_error", error, 1'b1);
    check("overlen_rx_ready", rx_ready, 1'b0);
    check("overlen_words", words_loaded, 16'd0);
    repeat (5) @(negedge clk);
    check("overlen_hold_rx_ready", rx_ready, 1'b0);
    check("overlen_cpu_hold", cpu_hold, 1'b1);

    // 5: gaps in rx_valid and start pulses mid-load
    push_two_words();
    pulse_start();
    set_nominal(8'ha1);
    send_stream(11, 1'b1, 1'b1);
    check_done_state("gaps");

    // 6: reset after five data bytes, then full reload
    exp_q.push_back('{addr: 32'd0, data: 32'h000007b7});
    pulse_start();
    set_nominal(8'ha1);
    send_stream(7, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_cpu_hold", cpu_hold, 1'b1);
    check("midrst_rx_ready", rx_ready, 1'b0);
    check("midrst_addr", imem_addr, 32'd0);
    check("midrst_words", words_loaded, 16'd0);
    check("midrst_imem_write", imem_write, 1'b0);
    check("midrst_done_error", {done, error}, 2'b00);
    check("midrst_pending_writes", exp_q.size(), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    push_two_words();
    pulse_start();
    send_stream(11, 1'b0, 1'b0);
    check_done_state("reload");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
